// File: rtl/player_link_pkg.sv
// Shared frame definitions for the inter-board player link (rx and tx sides).
// Holds the header byte, the byte positions and the decoded player/boss state.
package player_link_pkg;

    localparam logic [7:0] HEADER      = 8'hA5;
    localparam int         PKT_LEN     = 11;
    localparam int         PAYLOAD_LEN = 9;
    localparam logic [3:0] IDX_FIRST   = 4'd1;
    localparam logic [3:0] IDX_LAST    = 4'd9;
    localparam logic [3:0] IDX_CSUM    = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CHECK
    } rx_state_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [3:0]  hp;
        logic [3:0]  aggro;
        logic        flip_h;
        logic [1:0]  char_class;
        logic [11:0] boss_x;
        logic [11:0] boss_y;
        logic [6:0]  boss_hp;
    } player_state_t;

    // Payload bytes B1..B9, indexed by their position in the frame.
    typedef logic [PAYLOAD_LEN:1][7:0] payload_t;

    // Reserved bits (B5[4:0], B9[7]) are dropped here.
    function automatic player_state_t unpack_payload(input payload_t b);
        player_state_t s;
        s.x          = {b[1], b[2][7:4]};
        s.y          = {b[2][3:0], b[3]};
        s.hp         = b[4][7:4];
        s.aggro      = b[4][3:0];
        s.flip_h     = b[5][7];
        s.char_class = b[5][6:5];
        s.boss_x     = {b[6], b[7][7:4]};
        s.boss_y     = {b[7][3:0], b[8]};
        s.boss_hp    = b[9][6:0];
        return s;
    endfunction

endpackage

// File: rtl/link_watchdog.sv
// Saturating cycle counter with synchronous clear; flags expiry once LIMIT is reached.
module link_watchdog #(
    parameter int unsigned LIMIT = 65_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (en && (count_reg != W'(LIMIT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == W'(LIMIT));

endmodule

// File: rtl/player_link_rx.sv
// Frame deserialiser for the remote player/boss state with XOR check and link watchdog.
// Optional PLAYER_LINK_RX_ERRCNT_EN enables the saturating dropped-frame counter.
module player_link_rx
    import player_link_pkg::*;
#(
    parameter int unsigned BYTE_GAP_MAX = 65_000,
    parameter int unsigned LINK_TIMEOUT = 6_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [11:0] player_2_x,
    output logic [11:0] player_2_y,
    output logic [3:0]  player_2_hp,
    output logic [3:0]  player_2_aggro,
    output logic        player_2_flip_h,
    output logic [1:0]  player_2_class,
    output logic [11:0] boss_out_x,
    output logic [11:0] boss_out_y,
    output logic [6:0]  boss_out_hp,
    output logic        player_2_data_valid,
    output logic        pkt_strobe,
    output logic [7:0]  err_count
);
    rx_state_t     state_reg, state_next;
    logic [3:0]    idx_reg;
    logic [7:0]    xor_reg;
    logic [7:0]    shadow_reg [1:PAYLOAD_LEN];
    payload_t      shadow_flat;
    player_state_t data_reg;
    logic          valid_reg;
    logic          strobe_reg;

    logic start, load, frame_ok;
    logic gap_expired, link_expired;

    link_watchdog #(.LIMIT(BYTE_GAP_MAX)) u_gap (
        .clk     (clk),
        .rst     (rst),
        .en      (state_reg != ST_IDLE),
        .clear   (rx_valid || (state_reg == ST_IDLE)),
        .expired (gap_expired)
    );

    link_watchdog #(.LIMIT(LINK_TIMEOUT)) u_link (
        .clk     (clk),
        .rst     (rst),
        .en      (1'b1),
        .clear   (frame_ok),
        .expired (link_expired)
    );

    // A received byte always takes priority over a gap expiry in the same cycle.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        load       = 1'b0;
        frame_ok   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rx_valid && (rx_data == HEADER)) begin
                    start      = 1'b1;
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    load = 1'b1;
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_CHECK;
                    end
                end else if (gap_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    frame_ok   = (rx_data == xor_reg);
                    state_next = ST_IDLE;
                end else if (gap_expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            xor_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                idx_reg <= IDX_FIRST;
                xor_reg <= '0;
            end else if (load) begin
                idx_reg <= idx_reg + 1'b1;
                xor_reg <= xor_reg ^ rx_data;
            end
        end
    end

    generate
        for (genvar gi = 1; gi <= PAYLOAD_LEN; gi++) begin : g_shadow
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= '0;
                end else if (load && (idx_reg == 4'(gi))) begin
                    shadow_reg[gi] <= rx_data;
                end
            end
            assign shadow_flat[gi] = shadow_reg[gi];
        end
    endgenerate

    // Outputs change only on a verified frame; a good frame beats link expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
        end else begin
            strobe_reg <= frame_ok;
            if (frame_ok) begin
                data_reg  <= unpack_payload(shadow_flat);
                valid_reg <= 1'b1;
            end else if (link_expired) begin
                valid_reg <= 1'b0;
            end
        end
    end

`ifdef PLAYER_LINK_RX_ERRCNT_EN
    logic [7:0] err_reg;
    logic       drop;

    assign drop = ((state_reg == ST_CHECK) && rx_valid && (rx_data != xor_reg)) ||
                  ((state_reg != ST_IDLE) && !rx_valid && gap_expired);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= '0;
        end else if (drop && (err_reg != 8'hFF)) begin
            err_reg <= err_reg + 1'b1;
        end
    end

    assign err_count = err_reg;
`else
    assign err_count = 8'h00;
`endif

    assign player_2_x          = data_reg.x;
    assign player_2_y          = data_reg.y;
    assign player_2_hp         = data_reg.hp;
    assign player_2_aggro      = data_reg.aggro;
    assign player_2_flip_h     = data_reg.flip_h;
    assign player_2_class      = data_reg.char_class;
    assign boss_out_x          = data_reg.boss_x;
    assign boss_out_y          = data_reg.boss_y;
    assign boss_out_hp         = data_reg.boss_hp;
    assign player_2_data_valid = valid_reg;
    assign pkt_strobe          = strobe_reg;

endmodule

// File: tb/tb_player_link_rx.sv
// Scoreboard bench for player_link_rx: directed frames push expected state, a monitor
// pops and compares on every pkt_strobe. Short timer limits keep the run small.
module tb_player_link_rx;

    localparam int GAP  = 40;
    localparam int LINK = 300;
`ifdef PLAYER_LINK_RX_ERRCNT_EN
    localparam int ERRCNT = 1;
`else
    localparam int ERRCNT = 0;
`endif

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [3:0]  hp;
        logic [3:0]  aggro;
        logic        flip;
        logic [1:0]  cls;
        logic [11:0] bx;
        logic [11:0] by;
        logic [6:0]  bhp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [11:0] player_2_x, player_2_y, boss_out_x, boss_out_y;
    logic [3:0]  player_2_hp, player_2_aggro;
    logic        player_2_flip_h, player_2_data_valid, pkt_strobe;
    logic [1:0]  player_2_class;
    logic [6:0]  boss_out_hp;
    logic [7:0]  err_count;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   exp_cyc_q[$];
    logic [7:0] fb [0:10];

    player_link_rx #(.BYTE_GAP_MAX(GAP), .LINK_TIMEOUT(LINK)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .player_2_x          (player_2_x),
        .player_2_y          (player_2_y),
        .player_2_hp         (player_2_hp),
        .player_2_aggro      (player_2_aggro),
        .player_2_flip_h     (player_2_flip_h),
        .player_2_class      (player_2_class),
        .boss_out_x          (boss_out_x),
        .boss_out_y          (boss_out_y),
        .boss_out_hp         (boss_out_hp),
        .player_2_data_valid (player_2_data_valid),
        .pkt_strobe          (pkt_strobe),
        .err_count           (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic exp_t actual();
        return {player_2_x, player_2_y, player_2_hp, player_2_aggro, player_2_flip_h,
                player_2_class, boss_out_x, boss_out_y, boss_out_hp};
    endfunction

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Monitor: every strobe must match the oldest queued frame and arrive on time.
    always @(negedge clk) begin
        if (pkt_strobe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                int   c;
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("strobe_data", actual(), e);
                check("strobe_cycle", 66'(cyc), 66'(c));
                check("strobe_valid", 66'(player_2_data_valid), 66'd1);
            end
        end
    end

    task automatic make_frame(input exp_t f);
        logic [7:0] x;
        fb[0]  = 8'hA5;
        fb[1]  = f.x[11:4];
        fb[2]  = {f.x[3:0], f.y[11:8]};
        fb[3]  = f.y[7:0];
        fb[4]  = {f.hp, f.aggro};
        fb[5]  = {f.flip, f.cls, 5'b0};
        fb[6]  = f.bx[11:4];
        fb[7]  = {f.bx[3:0], f.by[11:8]};
        fb[8]  = f.by[7:0];
        fb[9]  = {1'b0, f.bhp};
        x = 8'h00;
        for (int i = 1; i <= 9; i++) x = x ^ fb[i];
        fb[10] = x;
    endtask

    task automatic send_raw(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    // Sends fb[first..last] back to back; a completed good frame is queued for the monitor.
    task automatic send_bytes(input int first, input int last, input bit good, input exp_t f);
        for (int i = first; i <= last; i++) begin
            send_raw(fb[i]);
            if (i == 10 && good) begin
                exp_q.push_back(f);
                exp_cyc_q.push_back(cyc + 1);
            end
        end
        go_idle(1);
    endtask

    exp_t f1, f3, f4, f6, zero;

    initial begin
        f1   = '{x:12'h123, y:12'h0F0, hp:4'd5, aggro:4'd3, flip:1'b1, cls:2'd2,
                 bx:12'h200, by:12'h1A0, bhp:7'd100};
        f3   = '{x:12'h456, y:12'h789, hp:4'd9, aggro:4'd1, flip:1'b0, cls:2'd1,
                 bx:12'h0AB, by:12'h3CD, bhp:7'd42};
        f4   = '{x:12'hA50, y:12'h0A5, hp:4'd15, aggro:4'd15, flip:1'b1, cls:2'd3,
                 bx:12'hFFF, by:12'h000, bhp:7'd127};
        f6   = '{x:12'h010, y:12'h020, hp:4'd1, aggro:4'd2, flip:1'b0, cls:2'd0,
                 bx:12'h030, by:12'h040, bhp:7'd7};
        zero = '0;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", actual(), zero);
        check("reset_valid", 66'(player_2_data_valid), 66'd0);
        check("reset_strobe", 66'(pkt_strobe), 66'd0);
        check("reset_err", 66'(err_count), 66'd0);

        // 1: good frame
        make_frame(f1);
        send_bytes(0, 10, 1'b1, f1);
        go_idle(1);
        check("t1_strobe_one_cycle", 66'(pkt_strobe), 66'd0);
        check("t1_valid", 66'(player_2_data_valid), 66'd1);
        check("t1_err", 66'(err_count), 66'd0);

        // 2: corrupted checksum
        make_frame(f1);
        fb[10] = fb[10] ^ 8'h01;
        send_bytes(0, 10, 1'b0, f1);
        go_idle(2);
        check("t2_data_held", actual(), f1);
        check("t2_err", 66'(err_count), 66'(ERRCNT * 1));

        // 3: stall past the byte gap after B4, then a full frame
        make_frame(f3);
        send_bytes(0, 4, 1'b0, f3);
        go_idle(GAP + 2);
        check("t3_data_after_drop", actual(), f1);
        send_bytes(0, 10, 1'b1, f3);
        go_idle(2);
        check("t3_err", 66'(err_count), 66'(ERRCNT * 2));
        check("t3_data", actual(), f3);

        // 4: garbage before header, header value inside the payload
        make_frame(f4);
        send_raw(8'h00);
        send_raw(8'h7F);
        send_bytes(0, 10, 1'b1, f4);
        go_idle(2);
        check("t4_err", 66'(err_count), 66'(ERRCNT * 2));
        check("t4_data", actual(), f4);

        // 5: link timeout
        go_idle(LINK - 20);
        check("t5_valid_before_timeout", 66'(player_2_data_valid), 66'd1);
        go_idle(30);
        check("t5_valid_after_timeout", 66'(player_2_data_valid), 66'd0);
        check("t5_data_held", actual(), f4);
        make_frame(f1);
        send_bytes(0, 10, 1'b1, f1);
        go_idle(1);
        check("t5_valid_restored", 66'(player_2_data_valid), 66'd1);

        // 6: reset in the middle of a frame (during B6)
        make_frame(f3);
        send_bytes(0, 5, 1'b0, f3);
        @(negedge clk);
        rx_data  = fb[6];
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b0;
        check("t6_reset_data", actual(), zero);
        check("t6_reset_valid", 66'(player_2_data_valid), 66'd0);
        check("t6_reset_err", 66'(err_count), 66'd0);
        make_frame(f6);
        send_bytes(0, 10, 1'b1, f6);
        go_idle(2);
        check("t6_data", actual(), f6);
        check("t6_err", 66'(err_count), 66'd0);

        go_idle(3);
        check("scoreboard_drained", 66'(exp_q.size()), 66'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
